// File: rtl/ram_rd_stream_pkg.sv
// Shared types and width helpers for the SRAM read-stream front end.
package ram_rd_stream_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Occupancy arithmetic width: FIFO count (<= 8) plus one in-flight read.
   localparam int OCC_W = 5;

   function automatic int len_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_skid.sv
// Small register FIFO absorbing bank read data; head is visible combinationally.
// Zero-latency pop from head, one-cycle push-to-visible; push and pop may coincide at any count.
module sync_fifo_skid
   import ram_rd_stream_pkg::*;
#(
   parameter int WIDTH = 129,
   parameter int DEPTH = 2,
   localparam int PW = ptr_width(DEPTH),
   localparam int CW = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop   = pop & ~empty;
   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ram_rd_stream.sv
// Burst reader for a 1-cycle-latency SRAM bank: one read per cycle, data on a valid/ready stream.
// Accept->first read 1 cycle, ->out_valid 3 cycles; reads are credit-throttled so out_ready low never drops data.
module ram_rd_stream
   import ram_rd_stream_pkg::*;
#(
   parameter int SRAM_WIDTH      = 128,
   parameter int SRAM_WORD       = 64,
   parameter int SRAM_ADDR_WIDTH = $clog2(SRAM_WORD),
   parameter int BUF_DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [SRAM_ADDR_WIDTH:0]   cmd_len,
   output logic                       ram_read_en,
   output logic [SRAM_ADDR_WIDTH-1:0] ram_addr_r,
   input  logic [SRAM_WIDTH-1:0]      ram_data_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SRAM_WIDTH-1:0]      out_data,
   output logic                       out_last,
   output logic                       busy
);

   localparam int LEN_W = len_width(SRAM_ADDR_WIDTH);
   localparam int CNT_W = cnt_width(BUF_DEPTH);
   localparam logic [LEN_W-1:0]           LEN_ONE   = LEN_W'(1);
   localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_LAST = SRAM_ADDR_WIDTH'(SRAM_WORD - 1);

   state_t                     state_q;
   state_t                     state_d;
   logic [SRAM_ADDR_WIDTH-1:0] addr_q;
   logic [SRAM_ADDR_WIDTH-1:0] addr_inc;
   logic [LEN_W-1:0]           remaining_q;
   logic                       inflight_q;
   logic                       inflight_last_q;
   logic                       accept;
   logic                       issue;
   logic                       pop;
   logic                       credit_ok;
   logic [OCC_W-1:0]           occ;
   logic [CNT_W-1:0]           fifo_count;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [SRAM_WIDTH:0]        head;

   // Words already buffered or on their way, net of the word leaving this cycle.
   assign pop       = out_valid & out_ready;
   assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
   assign credit_ok = (occ < OCC_W'(BUF_DEPTH));
   assign addr_inc  = (addr_q == ADDR_LAST) ? '0 : addr_q + SRAM_ADDR_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      issue     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept = 1'b1;
               if (cmd_len != '0) begin
                  state_d = ST_BURST;
               end
            end
         end
         ST_BURST: begin
            if ((remaining_q != '0) && credit_ok) begin
               issue = 1'b1;
               if (remaining_q == LEN_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         if (accept && (cmd_len != '0)) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
         end else if (issue) begin
            addr_q      <= addr_inc;
            remaining_q <= remaining_q - LEN_ONE;
         end
         inflight_q      <= issue;
         inflight_last_q <= issue && (remaining_q == LEN_ONE);
      end
   end

   assign ram_read_en = issue;
   assign ram_addr_r  = addr_q;

   sync_fifo_skid #(
      .WIDTH (SRAM_WIDTH + 1),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_dat ({inflight_last_q, ram_data_out}),
      .pop      (pop),
      .head_dat (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_data  = head[SRAM_WIDTH-1:0];
   assign out_last  = head[SRAM_WIDTH];
   assign busy      = (state_q == ST_BURST) | inflight_q | ~fifo_empty;

   // The read credit must make a push into a full, non-draining FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_ram_rd_stream.sv
// Randomized and directed checks of ram_rd_stream against a queue-based burst model.
module tb_ram_rd_stream;

   localparam int W  = 128;
   localparam int N  = 64;
   localparam int AW = 6;
   localparam int BD = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          ram_read_en;
   logic [AW-1:0] ram_addr_r;
   logic [W-1:0]  ram_data_out = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          busy;

   logic [W-1:0]  mem [N];
   logic [W:0]    exp_q[$];
   int            rd_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            rdy_mode = 0;
   int            outstanding = 0;
   logic          prev_stall = 1'b0;
   logic [W:0]    prev_word = '0;

   ram_rd_stream #(
      .SRAM_WIDTH      (W),
      .SRAM_WORD       (N),
      .SRAM_ADDR_WIDTH (AW),
      .BUF_DEPTH       (BD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .ram_read_en  (ram_read_en),
      .ram_addr_r   (ram_addr_r),
      .ram_data_out (ram_data_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Bank: data appears the cycle after the read and holds until the next read.
   always @(posedge clk) begin
      if (ram_read_en) ram_data_out <= mem[ram_addr_r];
   end

   always begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         rd_q.delete();
         outstanding <= 0;
         prev_stall  <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", {out_last, out_data}, prev_word);
         end
         if (ram_read_en) begin
            if (rd_q.size() == 0) chk("extra_read", 1, 0);
            else chk("rd_addr", ram_addr_r, rd_q.pop_front());
            chk("credit_bound",
                (outstanding + 1 - int'(out_valid && out_ready)) <= BD, 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 1, 0);
            else chk("out_word", {out_last, out_data}, exp_q.pop_front());
         end
         outstanding <= outstanding + int'(ram_read_en) - int'(out_valid && out_ready);
         prev_stall  <= out_valid && !out_ready;
         prev_word   <= {out_last, out_data};
      end
   end

   task automatic send_cmd(input int a, input int l, output int waits);
      int idx;
      cmd_addr  = AW'(a);
      cmd_len   = (AW + 1)'(l);
      cmd_valid = 1'b1;
      waits     = 0;
      @(negedge clk);
      while (!cmd_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         chk("cmd_accept_timeout", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         for (int k = 0; k < l; k++) begin
            idx = (a + k) % N;
            rd_q.push_back(idx);
            exp_q.push_back({1'(k == l - 1), mem[idx]});
         end
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      int c = 0;
      while ((exp_q.size() != 0 || busy) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk(tag, (exp_q.size() == 0) && !busy, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      int w2;
      for (int i = 0; i < N; i++) begin
         mem[i] = {$urandom(), $urandom(), $urandom(), 32'(i)};
      end

      #1 rst = 1'b1;
      #11;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_read_en", ram_read_en, 0);
      chk("rst_addr", ram_addr_r, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      #5 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single burst: latency and last-flag placement.
      send_cmd(5, 4, w);
      @(negedge clk);
      chk("lat_rd_en", ram_read_en, 1);
      chk("lat_rd_addr", ram_addr_r, 5);
      chk("lat_valid_c1", out_valid, 0);
      @(negedge clk);
      chk("lat_valid_c2", out_valid, 0);
      for (int c = 3; c <= 6; c++) begin
         @(negedge clk);
         chk("lat_valid", out_valid, 1);
         chk("lat_last", out_last, c == 6);
      end
      drain("drain_single");

      send_cmd(62, 4, w);
      drain("drain_wrap");

      // Back-pressure: out_ready low in cycles 4..9.
      send_cmd(10, 8, w);
      repeat (3) @(posedge clk);
      #1 rdy_mode = 2;
      repeat (5) @(negedge clk);
      chk("bp_read_stalled", ram_read_en, 0);
      chk("bp_valid_held", out_valid, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rdy_mode = 0;
      drain("drain_backpressure");

      send_cmd(0, 4, w);
      send_cmd(20, 2, w2);
      chk("b2b_accept_wait", w2, 4);
      drain("drain_b2b");

      send_cmd(9, 0, w);
      @(negedge clk);
      chk("zero_busy", busy, 0);
      chk("zero_read", ram_read_en, 0);
      chk("zero_ready", cmd_ready, 1);
      drain("drain_zero");

      send_cmd(17, 64, w);
      drain("drain_full_bank");

      // Reset in cycle 3 of a burst, then a fresh burst.
      send_cmd(30, 8, w);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_read_en", ram_read_en, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", out_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      send_cmd(40, 3, w);
      drain("drain_after_reset");

      rdy_mode = 1;
      for (int t = 0; t < 30; t++) begin
         int l;
         l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : int'($urandom_range(0, 6));
         send_cmd(int'($urandom_range(0, N - 1)), l, w);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain("drain_random");
      rdy_mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
